// File: rtl/uart_tx_sequencer.sv
// Feeds a latched 4-byte message, MSB byte first, to the UART transmitter over the
// Tx_WR/Tx_BUSY handshake, with one-shot/repeat modes, inter-byte gap and ack timeout.
module uart_tx_sequencer #(
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_W       = 8,
    parameter int ACK_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        repeat_en,
    input  logic        stop,
    input  logic [31:0] msg,
    input  logic        Tx_BUSY,
    output logic [7:0]  Tx_DATA,
    output logic        Tx_WR,
    output logic        Tx_EN,
    output logic        seq_busy,
    output logic [1:0]  byte_idx,
    output logic        done,
    output logic        ack_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    // A zero gap still spends one cycle in GAP, so both 0 and 1 end on count 0.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_shadow;
    logic [1:0]       r_idx;
    logic             r_stop;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [ACK_W-1:0] r_ack_cnt;
    logic [7:0]       r_tx_data;
    logic             r_tx_wr;
    logic             r_tx_en;
    logic             r_ack_err;

    logic             w_stop_any;
    logic             w_tx_wr_next;
    logic             w_tx_en_next;
    logic             w_ack_err_next;
    logic [7:0]       w_byte_sel;

    assign w_stop_any = stop | r_stop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_stop_any)    w_state_next = S_FINISH;
                else if (!Tx_BUSY) w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Tx_BUSY is checked first so a late ack on the last cycle still wins.
                if (Tx_BUSY)                     w_state_next = S_WAIT_DONE;
                else if (r_ack_cnt == ACK_LAST)  w_state_next = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!Tx_BUSY) begin
                    if (w_stop_any || (r_idx == 2'd3 && !repeat_en)) w_state_next = S_FINISH;
                    else                                             w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_stop_any)                 w_state_next = S_FINISH;
                else if (r_gap_cnt == GAP_LAST) w_state_next = S_WRITE;
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_byte_sel = 8'h00;
        unique case (r_idx)
            2'd0: w_byte_sel = r_shadow[31:24];
            2'd1: w_byte_sel = r_shadow[23:16];
            2'd2: w_byte_sel = r_shadow[15:8];
            2'd3: w_byte_sel = r_shadow[7:0];
        endcase

        w_tx_wr_next   = (r_state == S_WRITE) && !w_stop_any && !Tx_BUSY;
        w_ack_err_next = (r_state == S_WAIT_ACK) && !Tx_BUSY && (r_ack_cnt == ACK_LAST);

        w_tx_en_next = r_tx_en;
        if (r_state == S_IDLE && start)                 w_tx_en_next = 1'b1;
        if (w_state_next == S_FINISH || w_ack_err_next) w_tx_en_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow  <= '0;
            r_idx     <= '0;
            r_stop    <= 1'b0;
            r_gap_cnt <= '0;
            r_ack_cnt <= '0;
            r_tx_data <= '0;
            r_tx_wr   <= 1'b0;
            r_tx_en   <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_tx_wr   <= w_tx_wr_next;
            r_tx_en   <= w_tx_en_next;
            r_ack_err <= w_ack_err_next;
            if (w_tx_wr_next) r_tx_data <= w_byte_sel;

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shadow <= msg;
                        r_idx    <= 2'd0;
                        r_stop   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_ack_cnt <= '0;
                end
                S_WAIT_ACK: begin
                    if (!Tx_BUSY) r_ack_cnt <= r_ack_cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    r_gap_cnt <= '0;
                end
                S_GAP: begin
                    if (w_state_next == S_WRITE) begin
                        r_idx <= r_idx + 2'd1;
                        // Wrap only happens in repeat mode: pick up a new message here.
                        if (r_idx == 2'd3) r_shadow <= msg;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (r_state != S_IDLE && stop) r_stop <= 1'b1;
        end
    end

    assign Tx_DATA  = r_tx_data;
    assign Tx_WR    = r_tx_wr;
    assign Tx_EN    = r_tx_en;
    assign ack_err  = r_ack_err;
    assign byte_idx = r_idx;
    assign done     = (r_state == S_FINISH);
    assign seq_busy = (r_state != S_IDLE);

endmodule
